// File: rtl/fft_bf_sequencer.sv
// Butterfly sequencer for the 64-point radix-2 DIF in-place FFT.
// Issues RAM addresses and twiddle-ROM selects with an in-flight cap and stage drain.
module fft_bf_sequencer #(
    parameter int LOG2N        = 6,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             bf_valid,
    input  logic             bf_ready,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-1:0] tw_sel_re,
    output logic [LOG2N-1:0] tw_sel_im,
    output logic [2:0]       stage,
    input  logic             wb_done,
    output logic             err
);

    localparam int BW = LOG2N - 1;
    localparam logic [2:0] LAST_STAGE = 3'(LOG2N - 1);
    localparam logic [2:0] NSTAGE = 3'(LOG2N);
    localparam logic [BW-1:0] LAST_BF = '1;
    localparam logic [5:0] CAP = 6'(MAX_INFLIGHT);
    localparam logic [LOG2N-1:0] ONE = LOG2N'(1);
    localparam logic [LOG2N-1:0] HALF = ONE << (LOG2N - 1);
    // ROM holds -sin; a three-quarter-turn offset turns it into cos
    localparam logic [LOG2N-1:0] QTR3 = LOG2N'(3) << (LOG2N - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t        state_q, state_n;
    logic [2:0]    stage_q, stage_n;
    logic [BW-1:0] bf_q, bf_n;
    logic [5:0]    outst_q, outst_n;
    logic          err_q, err_n;
    logic          hs;

    logic [LOG2N-1:0] span, bfx, j, g, a, k;

    assign bf_valid = (state_q == S_ISSUE) && (outst_q < CAP);
    assign hs       = bf_valid & bf_ready;
    assign busy     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done     = (state_q == S_FIN);
    assign stage    = stage_q;
    assign err      = err_q;

    always_comb begin
        outst_n = outst_q;
        err_n   = err_q;
        if (hs && !wb_done) begin
            outst_n = outst_q + 6'd1;
        end else if (!hs && wb_done) begin
            if (outst_q == '0) begin
                err_n = 1'b1;
            end else begin
                outst_n = outst_q - 6'd1;
            end
        end
    end

    always_comb begin
        state_n = state_q;
        stage_n = stage_q;
        bf_n    = bf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n = S_ISSUE;
                    stage_n = '0;
                    bf_n    = '0;
                end
            end
            S_ISSUE: begin
                if (hs) begin
                    bf_n = bf_q + BW'(1);
                    if (bf_q == LAST_BF) begin
                        state_n = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // wait until every write of this stage has landed
                if (outst_n == '0) begin
                    if (stage_q == LAST_STAGE) begin
                        state_n = S_FIN;
                    end else begin
                        state_n = S_ISSUE;
                        stage_n = stage_q + 3'd1;
                        bf_n    = '0;
                    end
                end
            end
            S_FIN: begin
                state_n = S_IDLE;
                stage_n = '0;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        span = HALF >> stage_q;
        bfx  = {1'b0, bf_q};
        j    = bfx & (span - ONE);
        g    = bfx >> (LAST_STAGE - stage_q);
        a    = (g << (NSTAGE - stage_q)) | j;
        k    = j << stage_q;
        addr_a    = '0;
        addr_b    = '0;
        tw_sel_re = '0;
        tw_sel_im = '0;
        if (state_q == S_ISSUE) begin
            addr_a    = a;
            addr_b    = a + span;
            tw_sel_im = k;
            tw_sel_re = k + QTR3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            bf_q    <= '0;
            outst_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            stage_q <= stage_n;
            bf_q    <= bf_n;
            outst_q <= outst_n;
            err_q   <= err_n;
        end
    end

endmodule

// File: tb/tb_fft_bf_sequencer.sv
// Directed bench for fft_bf_sequencer: descriptor sequence, backpressure,
// in-flight cap, drain, reset and spurious writeback.
module tb_fft_bf_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       bf_ready = 1'b1;
    logic       wb_man = 1'b0;
    logic       auto_wb = 1'b1;
    logic       drop_last0 = 1'b0;
    logic       busy, done, bf_valid, err, wb_done;
    logic [5:0] addr_a, addr_b, tw_sel_re, tw_sel_im;
    logic [2:0] stage;

    logic [3:0] pipe = '0;
    int         hs_count = 0;
    int         done_count = 0;
    int         checks = 0;
    int         errors = 0;
    logic [5:0] la [256];
    logic [5:0] lb [256];
    logic [5:0] lre[256];
    logic [5:0] lim[256];
    logic       mon_hs;

    fft_bf_sequencer #(.LOG2N(6), .MAX_INFLIGHT(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done),
        .bf_valid(bf_valid), .bf_ready(bf_ready),
        .addr_a(addr_a), .addr_b(addr_b),
        .tw_sel_re(tw_sel_re), .tw_sel_im(tw_sel_im),
        .stage(stage), .wb_done(wb_done), .err(err)
    );

    initial forever #5 clk = ~clk;

    assign wb_done = (auto_wb & pipe[3]) | wb_man;
    assign mon_hs  = bf_valid & bf_ready;

    // Writeback model: echo each handshake 3 cycles later
    always @(negedge clk) begin
        if (rst) begin
            pipe       <= '0;
            hs_count   <= 0;
            done_count <= 0;
        end else begin
            pipe <= {pipe[2:0], mon_hs && !(drop_last0 && hs_count == 31)};
            if (mon_hs) begin
                la[hs_count[7:0]]  <= addr_a;
                lb[hs_count[7:0]]  <= addr_b;
                lre[hs_count[7:0]] <= tw_sel_re;
                lim[hs_count[7:0]] <= tw_sel_im;
                hs_count <= hs_count + 1;
            end
            if (done) done_count <= done_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        auto_wb = 1'b1;
        drop_last0 = 1'b0;
        wb_man = 1'b0;
        bf_ready = 1'b1;
        start = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_hs(input int target, input string tag);
        int n;
        for (n = 0; n < 2000; n++) begin
            if (hs_count >= target) break;
            tick(1);
        end
        chk(tag, (n < 2000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        for (n = 0; n < 3000; n++) begin
            tick(1);
            if (done) break;
        end
        chk(tag, (n < 3000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic chk_desc(input string tag, input int a, input int b,
                            input int re, input int im);
        chk({tag, "_a"}, 32'(addr_a), 32'(a));
        chk({tag, "_b"}, 32'(addr_b), 32'(b));
        chk({tag, "_re"}, 32'(tw_sel_re), 32'(re));
        chk({tag, "_im"}, 32'(tw_sel_im), 32'(im));
    endtask

    task automatic chk_log(input string tag, input int i, input int a,
                           input int b, input int re, input int im);
        chk({tag, "_a"}, 32'(la[i]), 32'(a));
        chk({tag, "_b"}, 32'(lb[i]), 32'(b));
        chk({tag, "_re"}, 32'(lre[i]), 32'(re));
        chk({tag, "_im"}, 32'(lim[i]), 32'(im));
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(bf_valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_stage", 32'(stage), 0);
        chk_desc("rst", 0, 0, 0, 0);

        // full transform with a stray start mid-run
        pulse_start();
        chk("run_valid", 32'(bf_valid), 1);
        chk("run_busy", 32'(busy), 1);
        chk_desc("s0b0", 0, 32, 48, 0);
        tick(10);
        chk("thruput", 32'(hs_count), 10);
        wait_hs(40, "wait40");
        pulse_start();
        wait_done("done1");
        chk("done_hi", 32'(done), 1);
        chk("done_busy", 32'(busy), 0);
        tick(1);
        chk("done_lo", 32'(done), 0);
        tick(3);
        chk("hs_total1", 32'(hs_count), 192);
        chk("done_cnt1", 32'(done_count), 1);
        chk("err_run1", 32'(err), 0);
        chk_log("s0b1", 1, 1, 33, 49, 1);
        chk_log("s1b16", 48, 32, 48, 48, 0);
        chk_log("s1b17", 49, 33, 49, 50, 2);
        chk_log("s5b3", 163, 6, 7, 48, 0);
        chk_log("s3b5", 101, 9, 13, 56, 8);

        // backpressure in stage 2 at b=6
        do_reset();
        pulse_start();
        wait_hs(70, "wait70");
        bf_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk_desc("hold", 6, 14, 8, 24);
            chk("hold_valid", 32'(bf_valid), 1);
            chk("hold_stage", 32'(stage), 2);
            chk("hold_hs", 32'(hs_count), 70);
        end
        bf_ready = 1'b1;
        wait_done("done2");
        tick(3);
        chk("hs_total2", 32'(hs_count), 192);
        chk("done_cnt2", 32'(done_count), 1);
        chk_log("bp_next", 70, 6, 14, 8, 24);
        chk_log("bp_after", 71, 7, 15, 12, 28);

        // in-flight cap with writebacks withheld
        do_reset();
        auto_wb = 1'b0;
        pulse_start();
        tick(6);
        chk("cap_hs4", 32'(hs_count), 4);
        chk("cap_valid0", 32'(bf_valid), 0);
        chk("cap_busy", 32'(busy), 1);
        wb_man = 1'b1;
        tick(1);
        wb_man = 1'b0;
        chk("cap_valid1", 32'(bf_valid), 1);
        tick(1);
        chk("cap_hs5", 32'(hs_count), 5);
        chk("cap_valid2", 32'(bf_valid), 0);
        tick(3);
        chk("cap_hs5b", 32'(hs_count), 5);
        chk("cap_err", 32'(err), 0);

        // drain: last stage-0 writeback arrives late
        do_reset();
        drop_last0 = 1'b1;
        pulse_start();
        wait_hs(32, "wait32");
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("drain_stage", 32'(stage), 0);
            chk("drain_valid", 32'(bf_valid), 0);
        end
        wb_man = 1'b1;
        tick(1);
        wb_man = 1'b0;
        chk("drain_next", 32'(stage), 1);
        chk("drain_valid1", 32'(bf_valid), 1);
        chk_desc("s1b0", 0, 16, 48, 0);
        wait_done("done3");
        tick(3);
        chk("hs_total3", 32'(hs_count), 192);
        chk("done_cnt3", 32'(done_count), 1);
        chk("err_run3", 32'(err), 0);

        // reset mid stage 3, then a clean transform
        do_reset();
        pulse_start();
        wait_hs(100, "wait100");
        chk("pre_stage3", 32'(stage), 3);
        rst = 1'b1;
        tick(1);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_valid", 32'(bf_valid), 0);
        chk("mid_done", 32'(done), 0);
        chk("mid_stage", 32'(stage), 0);
        chk_desc("mid", 0, 0, 0, 0);
        rst = 1'b0;
        tick(5);
        chk("mid_nodone", 32'(done_count), 0);
        pulse_start();
        wait_done("done4");
        tick(3);
        chk("hs_total4", 32'(hs_count), 192);
        chk("done_cnt4", 32'(done_count), 1);
        chk_log("re_s0b0", 0, 0, 32, 48, 0);

        // spurious writeback while idle
        do_reset();
        wb_man = 1'b1;
        tick(1);
        wb_man = 1'b0;
        chk("spur_err", 32'(err), 1);
        tick(3);
        chk("spur_sticky", 32'(err), 1);
        chk("spur_busy", 32'(busy), 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("spur_clr", 32'(err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_bf_sequencer.md
Name: fft_bf_sequencer

Overview:
- Control sequencer for the 64-point radix-2 in-place FFT engine.
- Walks all 6 decimation-in-frequency stages of 32 butterflies each.
- Per butterfly, issues the two RAM addresses and the two select codes for the twiddle ROM: real and imaginary part of W64^k.
- Stalls on datapath backpressure, caps the number of butterflies in flight, and drains writebacks between stages so the in-place update is free of read-after-write hazards.

Parameters:
- LOG2N, 6, log2 of transform size; the twiddle table and address widths are sized for 64 points.
- MAX_INFLIGHT, 4, maximum butterflies issued but not yet written back (1..32).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a transform; sampled only in IDLE.
- busy  out  1  high in ISSUE and DRAIN.
- done  out  1  one-cycle pulse when the transform completes.
- bf_valid  out  1  butterfly descriptor valid.
- bf_ready  in  1  datapath accepts the descriptor.
- addr_a  out  LOG2N  upper-leg RAM address.
- addr_b  out  LOG2N  lower-leg RAM address.
- tw_sel_re  out  LOG2N  twiddle-ROM select for the real part.
- tw_sel_im  out  LOG2N  twiddle-ROM select for the imaginary part.
- stage  out  3  current stage, 0..5.
- wb_done  in  1  one-cycle pulse per completed butterfly writeback.
- err  out  1  sticky; set by wb_done while nothing is outstanding.

Behaviour:
- Reset values: state IDLE; busy, done, bf_valid, err = 0; addr_a, addr_b, tw_sel_re, tw_sel_im, stage = 0; internal bf counter and outstanding counter = 0.
- States and transitions:
  - IDLE: start=1 -> ISSUE, with stage=0 and bf=0. bf_valid rises on the cycle after start.
  - ISSUE: bf_valid = (outstanding < MAX_INFLIGHT). A handshake is bf_valid & bf_ready; it increments bf. On the handshake with bf=31 -> DRAIN.
  - DRAIN: bf_valid=0. When the next outstanding value is 0 (counting a wb_done in the same cycle): if stage<5, go to ISSUE with stage+1 and bf=0; if stage=5, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Address generation, stage s, butterfly b (0..31):
  - span = 32>>s; j = b mod span; g = b / span.
  - addr_a = g*2*span + j; addr_b = addr_a + span.
  - Twiddle exponent k = (j << s) mod 64, range 0..31.
- Twiddle ROM mapping: entry m holds round(-256·sin(2πm/64)).
  - tw_sel_im = k.
  - tw_sel_re = (k + 48) mod 64; this entry holds cos(2πk/64)·256.
- Descriptor outputs are combinational from the registered state, stage and bf. They are held stable while bf_valid=1 and bf_ready=0.
- Outstanding counter (6 bits):
  - +1 on a handshake; -1 on wb_done; unchanged when both occur in the same cycle.
  - Never exceeds MAX_INFLIGHT.
- wb_done while outstanding=0 and no handshake this cycle: set err (sticky until rst) and leave the counter at 0.
- start while not in IDLE: ignored.
- rst mid-transform: returns to the reset values on the next edge; no done pulse; outstanding is cleared.
- Throughput: with bf_ready=1 and fast writebacks, one butterfly per cycle. Minimum inter-stage bubble is one DRAIN cycle.

Test Plan:
- Descriptor sequence: start with bf_ready=1 and wb_done echoed 3 cycles after each handshake.
  - Stage 0, b=0 -> a=0, b=32, re=48, im=0. b=1 -> 1, 33, 49, 1.
  - Stage 1, b=16 -> 32, 48, 48, 0. b=17 -> 33, 49, 50, 2.
  - Stage 5, b=3 -> 6, 7, 48, 0.
  - 192 handshakes total, then exactly one done pulse.
- Backpressure: drop bf_ready for 5 cycles mid-stage 2 -> the descriptor is held constant, bf does not advance, and no handshake is lost.
- In-flight cap: MAX_INFLIGHT=4 with wb_done withheld -> bf_valid drops after 4 handshakes; a single wb_done pulse allows exactly one more issue.
- Drain: delay the final stage-0 writeback 10 cycles -> stage stays 0 and bf_valid stays 0 until the writeback arrives, then stage becomes 1 on the next edge.
- Reset and start edge cases:
  - rst asserted during stage 3 -> all outputs 0 next cycle, no done pulse; a following start runs a clean 192-butterfly transform.
  - start pulsed while busy -> no effect on the sequence.
- Spurious writeback: wb_done while idle -> err=1 and stays 1 until rst.
